// File: rtl/mips_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_test_sequencer: holds a single-cycle MIPS core in reset, loads its   |
// | instruction memory, runs it to a halt PC or timeout and checks Result.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_test_sequencer #(
  parameter int DATA_W     = 32,
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = $clog2(PROG_DEPTH),
  parameter int RST_CYCLES = 3,
  parameter int RUN_CYCLES = 500,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] halt_pc,
  input  logic [DATA_W-1:0] expect_result,
  input  logic [DATA_W-1:0] dut_pc,
  input  logic [DATA_W-1:0] dut_result,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              dut_rst,
  output logic              dut_we,
  output logic [DATA_W-1:0] dut_w_ins,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0]  c_CNT_LAST  = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_live;
  logic [ADDR_W-1:0]   r_prog_addr;
  logic                r_dut_rst;
  logic                r_dut_we;
  logic [DATA_W-1:0]   r_dut_w_ins;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cycle_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_hold_cnt    <= '0;
      r_live        <= 1'b0;
      r_prog_addr   <= '0;
      r_dut_rst     <= 1'b1;
      r_dut_we      <= 1'b0;
      r_dut_w_ins   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_HOLD;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_hold_cnt    <= '0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            r_state     <= S_LOAD;
            r_prog_addr <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_dut_w_ins <= prog_data;
          r_dut_we    <= 1'b1;
          if (r_prog_addr == c_ADDR_LAST) begin
            r_state <= S_RUN;
            r_live  <= 1'b0;
          end else begin
            r_prog_addr <= r_prog_addr + 1'b1;
          end
        end
        S_RUN: begin
          // First RUN cycle still carries the last write; the core is released after it.
          if (!r_live) begin
            r_live    <= 1'b1;
            r_dut_rst <= 1'b0;
            r_dut_we  <= 1'b0;
          end else if (dut_pc == halt_pc) begin
            r_state <= S_CHECK;
          end else if (r_cycle_count == c_CNT_LAST) begin
            r_state   <= S_CHECK;
            r_timeout <= 1'b1;
          end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
          end
        end
        S_CHECK: begin
          r_pass    <= !r_timeout && (dut_result == expect_result);
          r_dut_rst <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_live    <= 1'b0;
          r_state   <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign prog_addr   = r_prog_addr;
  assign dut_rst     = r_dut_rst;
  assign dut_we      = r_dut_we;
  assign dut_w_ins   = r_dut_w_ins;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_test_sequencer: bench with a small behavioural MIPS core model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mips_test_sequencer;

  localparam int DEPTH  = 4;
  localparam int RSTC   = 3;
  localparam int RUNC   = 10;
  localparam int CNTW   = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] halt_pc = '0;
  logic [31:0] expect_result = '0;
  logic [31:0] prog_data;
  logic [31:0] dut_pc;
  logic [31:0] dut_result;
  logic [1:0]  prog_addr;
  logic        dut_rst, dut_we, busy, done, pass, timeout;
  logic [31:0] dut_w_ins;
  logic [CNTW-1:0] cycle_count;

  logic [31:0] rom [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign prog_data = rom[prog_addr];

  mips_test_sequencer #(
    .DATA_W(32), .PROG_DEPTH(DEPTH), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC), .CNT_W(CNTW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .prog_data(prog_data), .halt_pc(halt_pc),
    .expect_result(expect_result), .dut_pc(dut_pc), .dut_result(dut_result),
    .prog_addr(prog_addr), .dut_rst(dut_rst), .dut_we(dut_we), .dut_w_ins(dut_w_ins),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .cycle_count(cycle_count)
  );

  // Behavioural core: instruction memory filled through W_Ins/WE, executes addi/add/j.
  logic [31:0] imem [0:DEPTH-1];
  logic [31:0] regs [0:31];
  logic [31:0] core_pc, core_res;
  int          wptr;
  logic [31:0] cur_ins, simm, wval;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic        is_addi, is_add, is_j, wr;

  assign cur_ins = (core_pc < 32'(4 * DEPTH)) ? imem[core_pc[3:2]] : 32'h0;
  assign op      = cur_ins[31:26];
  assign rs      = cur_ins[25:21];
  assign rt      = cur_ins[20:16];
  assign rd      = cur_ins[15:11];
  assign funct   = cur_ins[5:0];
  assign simm    = {{16{cur_ins[15]}}, cur_ins[15:0]};
  assign is_addi = (op == 6'h08);
  assign is_add  = (op == 6'h00) && (funct == 6'h20);
  assign is_j    = (op == 6'h02);
  assign dst     = is_addi ? rt : rd;
  assign wval    = is_addi ? regs[rs] + simm : regs[rs] + regs[rt];
  assign wr      = (is_addi || is_add) && (dst != 5'd0);
  assign dut_pc     = core_pc;
  assign dut_result = core_res;

  always @(posedge CLK) begin
    if (dut_we) begin
      if (wptr < DEPTH) imem[wptr] <= dut_w_ins;
      wptr <= wptr + 1;
    end else begin
      wptr <= 0;
    end
    if (dut_rst) begin
      core_pc  <= 32'h0;
      core_res <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      core_pc <= is_j ? {core_pc[31:28], cur_ins[25:0], 2'b00} : core_pc + 32'd4;
      if (wr) begin
        regs[dst] <= wval;
        core_res  <= wval;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [31:0] a, input logic [31:0] b);
    rom[0] = 32'h20080000 | {16'h0, a[15:0]};
    rom[1] = 32'h20090000 | {16'h0, b[15:0]};
    rom[2] = 32'h01095020;
    rom[3] = 32'h08000003;
  endtask

  task automatic load_nops;
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
  endtask

  // Trace collected while a run proceeds
  int pre_we, n_we, word_err, overlap;
  bit rst_after_ok, seen_done, first_pass;

  task automatic pulse_start;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    bit seen_we = 1'b0;
    bit prev_we = 1'b0;
    pre_we = 0; n_we = 0; word_err = 0; overlap = 0;
    rst_after_ok = 1'b0; seen_done = 1'b0;
    pulse_start();
    first_pass = pass;
    for (int c = 0; c < budget && !seen_done; c++) begin
      if (busy && done) overlap++;
      if (dut_we) begin
        if (seen_we && !prev_we) word_err++;
        if (n_we < DEPTH) begin
          if (rom[n_we] !== dut_w_ins) word_err++;
        end
        n_we++;
        seen_we = 1'b1;
      end else if (!seen_we && busy) begin
        pre_we++;
      end
      if (prev_we && !dut_we) rst_after_ok = (dut_rst === 1'b0);
      prev_we = dut_we;
      if (done) seen_done = 1'b1;
      else @(negedge CLK);
    end
    chk("run_reached_done", seen_done, 1);
  endtask

  // Reference: program halting at 0xC with Result = a+b after 3 run cycles;
  // straight-line program halting at pc 4k, bounded by the run limit.
  task automatic expect_halt_prog(input string tag, input logic [31:0] sum, input logic [31:0] exp);
    chk({tag, "_pass"}, pass, (exp == sum) ? 1 : 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_count"}, cycle_count, 3);
  endtask

  initial begin
    load_prog(32'd5, 32'd3);

    // Reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_dut_we", dut_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_addr", prog_addr, 0);
    RST = 1'b0;

    // Load and halt with matching result
    halt_pc = 32'hC; expect_result = 32'd8;
    run_to_done(100);
    chk("load_hold_cycles", pre_we, RSTC + 1);
    chk("load_we_cycles", n_we, DEPTH);
    chk("load_word_errors", word_err, 0);
    chk("load_rst_falls_after", rst_after_ok, 1);
    chk("busy_done_overlap", overlap, 0);
    chk("halt_busy_low", busy, 0);
    expect_halt_prog("halt", 32'd8, expect_result);
    chk("halt_core_result", dut_result, 8);

    // Same run, mismatching expectation; restart from DONE clears flags
    expect_result = 32'd9;
    run_to_done(100);
    chk("restart_pass_cleared", first_pass, 0);
    expect_halt_prog("mismatch", 32'd8, expect_result);

    // Timeout: halt pc never reached
    halt_pc = 32'h100; expect_result = 32'd8;
    run_to_done(100);
    chk("tmo_timeout", timeout, 1);
    chk("tmo_pass", pass, 0);
    chk("tmo_count", cycle_count, RUNC - 1);

    // Halt on the same cycle as the run limit
    load_nops();
    halt_pc = 32'(4 * (RUNC - 1)); expect_result = 32'd0;
    run_to_done(100);
    chk("edge_timeout", timeout, 0);
    chk("edge_pass", pass, 1);
    chk("edge_count", cycle_count, RUNC - 1);

    // Abort: start ignored in LOAD, then reset mid-load
    load_prog(32'd5, 32'd3);
    halt_pc = 32'hC; expect_result = 32'd8;
    pulse_start();
    begin
      bit got_we = 1'b0;
      for (int c = 0; c < 20 && !got_we; c++) begin
        if (dut_we) got_we = 1'b1;
        else @(negedge CLK);
      end
      chk("abort_we_seen", got_we, 1);
    end
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("ignore_start_addr", prog_addr, 2);
    chk("ignore_start_word", dut_w_ins, rom[1]);
    chk("ignore_start_we", dut_we, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_we", dut_we, 0);
    chk("abort_addr", prog_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_dut_rst", dut_rst, 1);

    // Fresh complete run after abort
    run_to_done(100);
    chk("fresh_we_cycles", n_we, DEPTH);
    chk("fresh_word_errors", word_err, 0);
    expect_halt_prog("fresh", 32'd8, expect_result);

    // Randomized runs
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [31:0] a, b, sum;
        a = 32'($urandom_range(0, 32767));
        b = 32'($urandom_range(0, 32767));
        sum = a + b;
        load_prog(a, b);
        halt_pc = 32'hC;
        expect_result = ($urandom_range(0, 1) == 0) ? sum : sum + 32'($urandom_range(1, 100));
        run_to_done(100);
        chk("rnd_words", word_err, 0);
        expect_halt_prog("rnd_prog", sum, expect_result);
      end else begin
        int k;
        bit tmo;
        k = int'($urandom_range(0, 14));
        tmo = (k > RUNC - 1);
        load_nops();
        halt_pc = 32'(4 * k);
        expect_result = 32'd0;
        run_to_done(100);
        chk("rnd_nop_timeout", timeout, tmo ? 1 : 0);
        chk("rnd_nop_pass", pass, tmo ? 0 : 1);
        chk("rnd_nop_count", cycle_count, tmo ? RUNC - 1 : k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
